// File: rtl/dmem_bus_if.sv
// dmem_bus_if: single-outstanding request/ack data-RAM master for the memory stage.
// Optional BUSY timeout abort is compiled in with DMEM_TIMEOUT_EN.
module dmem_bus_if #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ce_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_we_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        bus_req_o,
  output logic [3:0]  bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_lane, r_size;
  logic        r_sign, r_load;
  logic        w_misal, w_accept, w_start, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_align;
  // Reserved size 11 is checked like a word
  assign w_misal  = (req_size_i == 2'b01) ? req_addr_i[0] :
                    (req_size_i != 2'b00) && (req_addr_i[1:0] != 2'b00);
  assign w_accept = (r_state == IDLE) && req_ce_i;
  assign w_start  = w_accept && !w_misal;
  assign stall_o  = rst && (w_accept || (r_state == BUSY));
  assign w_byte   = r_lane[1] ? (r_lane[0] ? bus_rdata_i[31:24] : bus_rdata_i[23:16]) :
                                (r_lane[0] ? bus_rdata_i[15:8]  : bus_rdata_i[7:0]);
  assign w_half   = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  assign w_align  = (r_size == 2'b00) ? {{24{r_sign & w_byte[7]}}, w_byte} :
                    (r_size == 2'b01) ? {{16{r_sign & w_half[15]}}, w_half} : bus_rdata_i;
`ifdef DMEM_TIMEOUT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= (r_state == BUSY) ? r_cnt + 16'd1 : '0;
  end
  assign w_timeout = r_cnt == 16'(TIMEOUT_CYC - 1);
`else
  assign w_timeout = TIMEOUT_CYC == 0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_ce_i ? (w_misal ? ERR : BUSY) : IDLE;
      BUSY:    w_next = bus_ack_i ? DONE : (w_timeout ? ERR : BUSY);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_lane      <= '0;
      r_size      <= '0;
      r_sign      <= 1'b0;
      r_load      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      r_state   <= w_next;
      done_o    <= (w_next == DONE) || (w_next == ERR);
      err_o     <= w_next == ERR;
      bus_req_o <= w_next == BUSY;
      rdata_o   <= ((r_state == BUSY) && bus_ack_i && r_load) ? w_align : '0;
      bus_we_o  <= w_start ? req_we_i : ((w_next == BUSY) ? bus_we_o : '0);
      if (w_accept) begin
        r_lane <= req_addr_i[1:0];
        r_size <= req_size_i;
        r_sign <= req_sign_i;
        r_load <= req_we_i == 4'b0000;
      end
      if (w_start) begin
        bus_addr_o  <= {req_addr_i[31:2], 2'b00};
        bus_wdata_o <= req_wdata_i;
      end
    end
  end
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed table-driven bench for dmem_bus_if plus reset/timeout sequences.
module tb_dmem_bus_if;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_ce = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_we = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_sign = 1'b0;
  logic        stall_o, done_o, err_o, bus_req_o;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_we_o;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  dmem_bus_if #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce), .req_addr_i(req_addr), .req_we_i(req_we),
    .req_wdata_i(req_wdata), .req_size_i(req_size), .req_sign_i(req_sign),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] bdata;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int   stalls = 0;
    int   nbusy = 0;
    logic got = 1'b0;
    logic saw = 1'b0;
    @(posedge clk);
    #1;
    req_ce = 1'b1; req_addr = v.addr; req_we = v.we; req_wdata = v.wdata;
    req_size = v.size; req_sign = v.sign;
    for (int g = 0; g < 400 && !got; g++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
      end else begin
        stalls += int'(stall_o);
        if (bus_req_o) begin
          nbusy++;
          saw = 1'b1;
          chk($sformatf("v%0d_bus_addr", idx), bus_addr_o, v.addr & 32'hFFFF_FFFC);
          chk($sformatf("v%0d_bus_we", idx), 32'(bus_we_o), 32'(v.we));
          chk($sformatf("v%0d_bus_wdata", idx), bus_wdata_o, v.wdata);
          req_addr = ~v.addr; req_we = ~v.we; req_wdata = ~v.wdata;
          req_size = ~v.size; req_sign = ~v.sign;
          bus_ack = nbusy == v.waits + 1;
          bus_rdata = bus_ack ? v.bdata : ~v.bdata;
        end
      end
    end
    chk($sformatf("v%0d_done", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_err", idx), 32'(err_o), 32'(v.exp_err));
    chk($sformatf("v%0d_rdata", idx), rdata_o, v.exp_rdata);
    chk($sformatf("v%0d_stall_at_done", idx), 32'(stall_o), 32'd0);
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), v.exp_err ? 32'd1 : 32'(v.waits + 2));
    chk($sformatf("v%0d_bus_used", idx), 32'(saw), 32'(!v.exp_err));
    bus_ack = 1'b0;
    req_ce = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{32'h0000_0103, 4'h0, 32'h0,         2'd0, 1'b1, 32'h80AA_BBCC, 0,   32'hFFFF_FF80, 1'b0};
    tv[1]  = '{32'h0000_0102, 4'h0, 32'h0,         2'd1, 1'b0, 32'h8001_1234, 3,   32'h0000_8001, 1'b0};
    tv[2]  = '{32'h0000_0200, 4'h3, 32'h0000_BEEF, 2'd1, 1'b0, 32'hDEAD_BEEF, 1,   32'h0,         1'b0};
    tv[3]  = '{32'h0000_0102, 4'h0, 32'h0,         2'd2, 1'b0, 32'h1111_1111, 0,   32'h0,         1'b1};
    tv[4]  = '{32'h0000_0101, 4'h0, 32'h0,         2'd0, 1'b0, 32'h1234_F678, 2,   32'h0000_00F6, 1'b0};
    tv[5]  = '{32'h0000_0300, 4'h0, 32'h0,         2'd1, 1'b1, 32'h7FFF_8001, 2,   32'hFFFF_8001, 1'b0};
    tv[6]  = '{32'h0000_0404, 4'h0, 32'h0,         2'd2, 1'b1, 32'hCAFE_F00D, 0,   32'hCAFE_F00D, 1'b0};
    tv[7]  = '{32'h0000_0406, 4'h0, 32'h0,         2'd3, 1'b0, 32'h2222_2222, 0,   32'h0,         1'b1};
    tv[8]  = '{32'h0000_0408, 4'h0, 32'h0,         2'd3, 1'b0, 32'h8765_4321, 1,   32'h8765_4321, 1'b0};
    tv[9]  = '{32'h0000_0101, 4'h0, 32'h0,         2'd1, 1'b1, 32'h3333_3333, 0,   32'h0,         1'b1};
    tv[10] = '{32'h0000_0102, 4'h0, 32'h0,         2'd0, 1'b1, 32'h007F_0000, 0,   32'h0000_007F, 1'b0};
    tv[11] = '{32'h0000_050C, 4'hF, 32'h1122_3344, 2'd2, 1'b0, 32'h5555_5555, 3,   32'h0,         1'b0};

    req_ce = 1'b1;
    #12;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_bus_we", 32'(bus_we_o), 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    req_ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_done", 32'(done_o), 32'd0);
    chk("idle_ack_bus_req", 32'(bus_req_o), 32'd0);
    bus_ack = 1'b0;

    for (int i = 0; i < 12; i++) run(tv[i], i);

`ifdef DMEM_TIMEOUT_EN
    begin
      int   nb = 0;
      logic got = 1'b0;
      @(posedge clk);
      #1;
      req_ce = 1'b1; req_addr = 32'h600; req_we = 4'h0; req_size = 2'd2; req_sign = 1'b0;
      for (int g = 0; g < 50 && !got; g++) begin
        @(negedge clk);
        if (done_o) got = 1'b1;
        else nb += int'(bus_req_o);
      end
      chk("to_done", 32'(got), 32'd1);
      chk("to_busy_cycles", 32'(nb), 32'd4);
      chk("to_err", 32'(err_o), 32'd1);
      chk("to_rdata", rdata_o, 32'd0);
      chk("to_bus_req", 32'(bus_req_o), 32'd0);
      req_ce = 1'b0;
    end
`else
    run('{32'h0000_0600, 4'h0, 32'h0, 2'd2, 1'b0, 32'h600D_600D, 120, 32'h600D_600D, 1'b0}, 99);
`endif

    @(posedge clk);
    #1;
    req_ce = 1'b1; req_addr = 32'h700; req_we = 4'h0; req_size = 2'd2; req_sign = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_req", 32'(bus_req_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    req_ce = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ack_done", 32'(done_o), 32'd0);
    chk("late_ack_bus_req", 32'(bus_req_o), 32'd0);
    bus_ack = 1'b0;
    run(tv[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
